// File: rtl/rr_arb8.sv
// rr_arb8: 8-way round-robin arbiter with a per-grant hold limit.
// One grant at a time; at least one idle cycle between consecutive grants.
module rr_arb8 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     r_state;
    state_t     w_state_nx;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nx;
    logic [7:0] r_hold;
    logic [7:0] w_hold_nx;
    logic [7:0] r_grant;
    logic [7:0] w_grant_nx;
    logic [2:0] r_idx;
    logic [2:0] w_idx_nx;
    logic       r_valid;
    logic       w_valid_nx;
    logic       r_timeout;
    logic       w_timeout_nx;

    logic [15:0] w_dbl;
    logic [15:0] w_shift;
    logic [7:0]  w_rot;
    logic [2:0]  w_off;
    logic [2:0]  w_pick;
    logic        w_req_any;
    logic        w_owner_req;
    logic        w_hold_end;

    // Rotate so that bit 0 of w_rot is requester r_ptr.
    assign w_dbl       = {req, req};
    assign w_shift     = w_dbl >> r_ptr;
    assign w_rot       = w_shift[7:0];
    assign w_pick      = r_ptr + w_off;
    assign w_req_any   = |req;
    assign w_owner_req = req[r_idx];
    assign w_hold_end  = (r_hold == HOLD_LAST);

    always_comb begin
        w_off = 3'd0;
        for (int j = 7; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = 3'(j);
            end
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_ptr_nx     = r_ptr;
        w_hold_nx    = r_hold;
        w_grant_nx   = r_grant;
        w_idx_nx     = r_idx;
        w_valid_nx   = r_valid;
        w_timeout_nx = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req_any) begin
                    w_state_nx = BUSY;
                    w_grant_nx = 8'b0000_0001 << w_pick;
                    w_idx_nx   = w_pick;
                    w_valid_nx = 1'b1;
                    w_hold_nx  = 8'd0;
                end
            end
            BUSY: begin
                if (done || !w_owner_req || w_hold_end) begin
                    w_state_nx   = IDLE;
                    w_grant_nx   = 8'h00;
                    w_idx_nx     = 3'd0;
                    w_valid_nx   = 1'b0;
                    w_hold_nx    = 8'd0;
                    w_ptr_nx     = r_idx + 3'd1;
                    // Hold limit only counts as a timeout if nothing else released.
                    w_timeout_nx = !done && w_owner_req;
                end else begin
                    w_hold_nx = w_hold_end ? r_hold : r_hold + 8'd1;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= 3'd0;
            r_hold    <= 8'd0;
            r_grant   <= 8'h00;
            r_idx     <= 3'd0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_ptr     <= w_ptr_nx;
            r_hold    <= w_hold_nx;
            r_grant   <= w_grant_nx;
            r_idx     <= w_idx_nx;
            r_valid   <= w_valid_nx;
            r_timeout <= w_timeout_nx;
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_idx;
    assign grant_valid = r_valid;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_arb8.sv
// tb_rr_arb8: directed and randomized checks of rr_arb8 against
// a cycle-level behavioural model of the arbitration rules.
module tb_rr_arb8;

    localparam int HM = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    int m_owner = -1;
    int m_ptr = 0;
    int m_hold = 0;
    bit m_to = 1'b0;

    logic [12:0] obs;
    assign obs = {grant, grant_idx, grant_valid, timeout};

    rr_arb8 #(.HOLD_MAX(HM)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .done(done),
        .grant(grant),
        .grant_idx(grant_idx),
        .grant_valid(grant_valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_owner = -1;
        m_ptr = 0;
        m_hold = 0;
        m_to = 1'b0;
    endfunction

    // One rising edge worth of the arbitration rules.
    function automatic void model_step(logic [7:0] r, logic d);
        int i;
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < 8; k++) begin
                i = (m_ptr + k) % 8;
                if (r[i] && m_owner < 0) begin
                    m_owner = i;
                    m_hold = 0;
                end
            end
        end else if (d || !r[m_owner] || m_hold == HM - 1) begin
            m_to = !d && r[m_owner];
            m_ptr = (m_owner + 1) % 8;
            m_owner = -1;
            m_hold = 0;
        end else begin
            m_hold = (m_hold + 1 > HM - 1) ? HM - 1 : m_hold + 1;
        end
    endfunction

    function automatic logic [12:0] model_out();
        if (m_owner >= 0)
            return {8'(1 << m_owner), 3'(m_owner), 1'b1, m_to};
        return {8'h00, 3'd0, 1'b0, m_to};
    endfunction

    function automatic logic [12:0] busy_vec(int idx);
        return {8'(1 << idx), 3'(idx), 1'b1, 1'b0};
    endfunction

    task automatic tick(input logic [7:0] r, input logic d);
        req = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 8'h00;
        done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 13'h0) begin
            errors++;
            $display("FAIL reset_async got %h exp %h", obs, 13'h0);
        end
        req = 8'hFF;
        done = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== 13'h0) begin
            errors++;
            $display("FAIL reset_hold got %h exp %h", obs, 13'h0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick(8'hFF, 1'b0);
        checks++;
        if (obs !== busy_vec(0)) begin
            errors++;
            $display("FAIL reset_first_grant got %h exp %h", obs, busy_vec(0));
        end
        tick(8'h00, 1'b0);
    endtask

    task automatic test_single();
        do_reset();
        tick(8'h04, 1'b0);
        checks++;
        if (obs !== busy_vec(2)) begin
            errors++;
            $display("FAIL single_grant got %h exp %h", obs, busy_vec(2));
        end
        tick(8'h04, 1'b1);
        checks++;
        if (obs !== 13'h0) begin
            errors++;
            $display("FAIL single_release got %h exp %h", obs, 13'h0);
        end
        tick(8'h0C, 1'b0);
        checks++;
        if (obs !== busy_vec(3)) begin
            errors++;
            $display("FAIL single_ptr got %h exp %h", obs, busy_vec(3));
        end
        tick(8'h00, 1'b0);
    endtask

    task automatic test_rotation();
        do_reset();
        for (int k = 0; k < 9; k++) begin
            tick(8'hFF, 1'b0);
            checks++;
            if (obs !== busy_vec(k % 8)) begin
                errors++;
                $display("FAIL rotation_grant%0d got %h exp %h", k, obs, busy_vec(k % 8));
            end
            tick(8'hFF, 1'b1);
            checks++;
            if (obs !== 13'h0) begin
                errors++;
                $display("FAIL rotation_idle%0d got %h exp %h", k, obs, 13'h0);
            end
        end
        tick(8'h00, 1'b0);
    endtask

    task automatic test_wrap();
        do_reset();
        tick(8'h80, 1'b0);
        tick(8'h80, 1'b1);
        tick(8'h81, 1'b0);
        checks++;
        if (obs !== busy_vec(0)) begin
            errors++;
            $display("FAIL wrap got %h exp %h", obs, busy_vec(0));
        end
        tick(8'h00, 1'b0);
    endtask

    task automatic test_timeout();
        do_reset();
        tick(8'h10, 1'b0);
        for (int j = 0; j < HM; j++) begin
            checks++;
            if (obs !== busy_vec(4)) begin
                errors++;
                $display("FAIL timeout_hold%0d got %h exp %h", j, obs, busy_vec(4));
            end
            tick(8'h10, 1'b0);
        end
        checks++;
        if (obs !== 13'h0001) begin
            errors++;
            $display("FAIL timeout_pulse got %h exp %h", obs, 13'h0001);
        end
        tick(8'h00, 1'b0);
        checks++;
        if (obs !== 13'h0) begin
            errors++;
            $display("FAIL timeout_single got %h exp %h", obs, 13'h0);
        end
        tick(8'h30, 1'b0);
        checks++;
        if (obs !== busy_vec(5)) begin
            errors++;
            $display("FAIL timeout_ptr got %h exp %h", obs, busy_vec(5));
        end
        tick(8'h00, 1'b0);
        tick(8'h10, 1'b0);
        repeat (HM - 1) tick(8'h10, 1'b0);
        tick(8'h10, 1'b1);
        checks++;
        if (obs !== 13'h0) begin
            errors++;
            $display("FAIL timeout_done_prec got %h exp %h", obs, 13'h0);
        end
    endtask

    task automatic test_drop();
        do_reset();
        tick(8'h08, 1'b0);
        tick(8'hFF, 1'b0);
        checks++;
        if (obs !== busy_vec(3)) begin
            errors++;
            $display("FAIL drop_stable got %h exp %h", obs, busy_vec(3));
        end
        tick(8'hF7, 1'b0);
        checks++;
        if (obs !== 13'h0) begin
            errors++;
            $display("FAIL drop_release got %h exp %h", obs, 13'h0);
        end
        tick(8'h27, 1'b0);
        checks++;
        if (obs !== busy_vec(5)) begin
            errors++;
            $display("FAIL drop_next got %h exp %h", obs, busy_vec(5));
        end
        tick(8'h00, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(8'h20, 1'b0);
        checks++;
        if (obs !== busy_vec(5)) begin
            errors++;
            $display("FAIL rstmid_grant got %h exp %h", obs, busy_vec(5));
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs !== 13'h0) begin
            errors++;
            $display("FAIL rstmid_clear got %h exp %h", obs, 13'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(8'h21, 1'b0);
        checks++;
        if (obs !== busy_vec(0)) begin
            errors++;
            $display("FAIL rstmid_after got %h exp %h", obs, busy_vec(0));
        end
        tick(8'h00, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0]  r;
        logic        d;
        logic [12:0] e;
        do_reset();
        r = 8'h00;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0)
                r = 8'($urandom);
            else if ($urandom_range(0, 7) == 0)
                r = r & ~(8'(1) << $urandom_range(0, 7));
            d = ($urandom_range(0, 4) == 0);
            tick(r, d);
            e = model_out();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL random%0d req %h done %b got %h exp %h", n, r, d, obs, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_timeout();
        test_drop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arb8.md
RR_ARB8 -- requirements
Module: rr_arb8

Interface
Parameters:
REQ-001 The block SHALL have parameter HOLD_MAX, default 16, meaning the maximum number of cycles one grant may be held; legal range 2..255.

Ports:
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port req, input, 8 bits: request vector; bit i set means requester i wants the resource.
REQ-005 The block SHALL have port done, input, 1 bit: the current owner releases the resource; sampled only in BUSY.
REQ-006 The block SHALL have port grant, output, 8 bits: registered one-hot grant; all-zero when no grant is held.
REQ-007 The block SHALL have port grant_idx, output, 3 bits: registered binary index of the granted requester; 3'b000 when no grant is held.
REQ-008 The block SHALL have port grant_valid, output, 1 bit: high exactly while grant is non-zero.
REQ-009 The block SHALL have port timeout, output, 1 bit: a one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE (no grant) and BUSY (one grant held).
REQ-011 The block SHALL keep a 3-bit rotating priority pointer ptr; the search order is ptr, ptr+1, ..., ptr+7, all modulo 8.
REQ-012 In IDLE with req != 0 at a rising edge, the block SHALL select the first set bit in the search order, register grant/grant_idx/grant_valid on that edge, enter BUSY, and clear the hold counter; latency from req to grant is 1 cycle.
REQ-013 In IDLE with req == 0, the block SHALL stay in IDLE with all outputs zero.
REQ-014 In IDLE, done SHALL be ignored.
REQ-015 In BUSY, grant and grant_idx SHALL stay constant, whatever the other req bits do.
REQ-016 In BUSY, the hold counter SHALL increment by 1 per cycle, saturating at HOLD_MAX-1.
REQ-017 In BUSY, release SHALL occur on the edge where any of these holds: done==1, req[grant_idx]==0, or hold counter == HOLD_MAX-1.
REQ-018 On release, the block SHALL return to IDLE, clear grant, grant_idx and grant_valid on that edge, and set ptr = grant_idx+1 mod 8 (7 wraps to 0).
REQ-019 A new grant SHALL NOT be issued on the release edge; at least one IDLE cycle separates consecutive grants.
REQ-020 timeout SHALL pulse high for exactly the one cycle after a release caused only by the hold limit; done or a dropped request on the same edge take precedence, and timeout stays 0.
REQ-021 Outputs SHALL be driven only from flops, with no combinational path from req or done to any output.
REQ-022 A requester holding req continuously SHALL wait at most 7 other grants before being granted (starvation-free).

Reset
REQ-023 Asserting rst_n low SHALL immediately force state=IDLE, ptr=0, hold counter=0, grant=8'h00, grant_idx=3'b000, grant_valid=0 and timeout=0, including mid-grant.
REQ-024 After rst_n deasserts, the first grant SHALL be evaluated on the first rising edge, with ptr=0.

Verification
REQ-025 Single request: req=8'h04 from IDLE -> next cycle grant=8'h04, grant_idx=2, grant_valid=1; done=1 for one cycle -> next cycle all outputs 0 and ptr=3.
REQ-026 Rotation: req=8'hFF held, done pulsed each BUSY cycle -> grant_idx sequence is 0,1,2,...,7,0, with an idle cycle between each grant.
REQ-027 Pointer wrap: after a grant to 7 is released, req=8'h81 -> grant_idx=0 (not 7).
REQ-028 Timeout: HOLD_MAX=4, req=8'h10 held, done=0 -> grant held for 4 cycles, then release, with timeout=1 for exactly one cycle and ptr=5.
REQ-029 Request drop: granted to 3, req[3] goes to 0 with other bits set -> release on that edge; the next grant comes after the idle cycle, from index 4 onward.
REQ-030 Reset mid-grant: rst_n low while grant=8'h20 -> outputs go to 0 asynchronously; after release with req=8'h21, grant_idx=0.
